// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, stopping at the first differing digit. Supports
// unsigned or two's-complement ordering behind a start/busy/done handshake.
module seq_mag_comparator #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1,
  parameter int CNTW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_GT_B,
  output logic             A_LT_B,
  output logic             A_EQ_B,
  output logic [CNTW-1:0]  DIG_CNT
);

  localparam int              NUM_DIGITS   = WIDTH / DIGIT;
  localparam logic [CNTW-1:0] NUM_DIGITS_C = CNTW'(NUM_DIGITS);
  localparam logic [CNTW-1:0] LAST_IDX_C   = CNTW'(NUM_DIGITS - 1);
  localparam logic [CNTW-1:0] ONE_C        = CNTW'(1'b1);
  localparam logic [WIDTH-1:0] MSB_MASK_C  = WIDTH'(1'b1) << (WIDTH - 1);

  // Operands must split into whole digits; flag a bad instance when elaborated.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("seq_mag_comparator: WIDTH (%0d) is not a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t            state_r, state_s;
  // Operands are shifted left one digit per step, so the digit under test is
  // always the top DIGIT bits; idx_r tracks which digit that is.
  logic [WIDTH-1:0]  a_r, a_s;
  logic [WIDTH-1:0]  b_r, b_s;
  logic [CNTW-1:0]   idx_r, idx_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              gt_r, gt_s;
  logic              lt_r, lt_s;
  logic              eq_r, eq_s;
  logic [CNTW-1:0]   cnt_r, cnt_s;
  logic [DIGIT-1:0]  a_dig_s;
  logic [DIGIT-1:0]  b_dig_s;
  logic [WIDTH-1:0]  flip_s;

  // Next-state, datapath and output decode for the IDLE/COMPARE controller.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    gt_s    = gt_r;
    lt_s    = lt_r;
    eq_s    = eq_r;
    cnt_s   = cnt_r;
    a_dig_s = a_r[WIDTH-1 -: DIGIT];
    b_dig_s = b_r[WIDTH-1 -: DIGIT];
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    flip_s  = signed_mode ? MSB_MASK_C : {WIDTH{1'b0}};

    case (state_r)
      IDLE: begin
        if (start) begin
          a_s     = A ^ flip_s;
          b_s     = B ^ flip_s;
          idx_s   = LAST_IDX_C;
          gt_s    = 1'b0;
          lt_s    = 1'b0;
          eq_s    = 1'b0;
          cnt_s   = {CNTW{1'b0}};
          state_s = COMPARE;
        end else begin
          state_s = IDLE;
        end
      end
      COMPARE: begin
        if (a_dig_s > b_dig_s) begin
          gt_s    = 1'b1;
          cnt_s   = NUM_DIGITS_C - idx_r;
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (a_dig_s < b_dig_s) begin
          lt_s    = 1'b1;
          cnt_s   = NUM_DIGITS_C - idx_r;
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (idx_r == {CNTW{1'b0}}) begin
          eq_s    = 1'b1;
          cnt_s   = NUM_DIGITS_C;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          a_s     = a_r << DIGIT;
          b_s     = b_r << DIGIT;
          idx_s   = idx_r - ONE_C;
          state_s = COMPARE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == COMPARE);
  end

  // State, operand and registered-output update with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      idx_r   <= {CNTW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      eq_r    <= 1'b0;
      cnt_r   <= {CNTW{1'b0}};
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      idx_r   <= idx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      gt_r    <= gt_s;
      lt_r    <= lt_s;
      eq_r    <= eq_s;
      cnt_r   <= cnt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign A_GT_B  = gt_r;
  assign A_LT_B  = lt_r;
  assign A_EQ_B  = eq_r;
  assign DIG_CNT = cnt_r;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: three instances (4/1, 8/2, 8/8),
// directed vectors push expected results; a monitor pops them on done.
module tb_seq_mag_comparator;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_v [3];
  logic       sm_v    [3];
  logic [7:0] a_v     [3];
  logic [7:0] b_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       gt_v    [3];
  logic       lt_v    [3];
  logic       eq_v    [3];
  logic [3:0] dcnt_v  [3];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         g;
    logic [2:0] flags;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  // Free-running clock.
  always #5 clock = ~clock;

  // Edge counter used to predict when each done strobe must appear.
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 4 : 8;
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    seq_mag_comparator #(.WIDTH(W), .DIGIT(D), .CNTW(4)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start_v[g]),
      .signed_mode(sm_v[g]),
      .A          (a_v[g][W-1:0]),
      .B          (b_v[g][W-1:0]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .A_GT_B     (gt_v[g]),
      .A_LT_B     (lt_v[g]),
      .A_EQ_B     (eq_v[g]),
      .DIG_CNT    (dcnt_v[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a start at the current negedge and record the expected result.
  task automatic launch(input int g, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [2:0] flags, input int k);
    exp_t e;
    a_v[g]     = a;
    b_v[g]     = b;
    sm_v[g]    = sm;
    start_v[g] = 1'b1;
    e.g     = g;
    e.flags = flags;
    e.cnt   = 4'(k);
    e.cyc   = cyc + 1 + k;
    exp_q.push_back(e);
    @(negedge clock);
    start_v[g] = 1'b0;
  endtask

  // Wait (bounded) for the done strobe of instance g.
  task automatic wait_done(input int g);
    bit got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done_v[g]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk($sformatf("done_timeout[%0d]", g), int'(done_v[g]), 1);
  endtask

  // Monitor: flags must be clear while busy; each done pops and checks one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      for (int g = 0; g < 3; g++) begin
        if (busy_v[g]) begin
          chk($sformatf("flags_while_busy[%0d]", g), int'({gt_v[g], lt_v[g], eq_v[g]}), 0);
        end
        if (done_v[g]) begin
          if (exp_q.size() == 0 || exp_q[0].g != g) begin
            chk($sformatf("unexpected_done[%0d]", g), int'(done_v[g]), 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("flags[%0d]", g), int'({gt_v[g], lt_v[g], eq_v[g]}), int'(e.flags));
            chk($sformatf("dig_cnt[%0d]", g), int'(dcnt_v[g]), int'(e.cnt));
            chk($sformatf("done_cycle[%0d]", g), cyc, e.cyc);
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      sm_v[g]    = 1'b0;
      a_v[g]     = 8'h00;
      b_v[g]     = 8'h00;
    end
    repeat (3) @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_busy[%0d]", g), int'(busy_v[g]), 0);
      chk($sformatf("rst_done[%0d]", g), int'(done_v[g]), 0);
      chk($sformatf("rst_flags[%0d]", g), int'({gt_v[g], lt_v[g], eq_v[g]}), 0);
      chk($sformatf("rst_cnt[%0d]", g), int'(dcnt_v[g]), 0);
    end
    reset = 1'b1;
    @(negedge clock);

    // 4/1 unsigned, then a second compare started in the done cycle.
    launch(0, 8'h0A, 8'h09, 1'b0, GT, 3);
    wait_done(0);
    launch(0, 8'h0E, 8'h0F, 1'b0, LT, 4);
    wait_done(0);

    // 8/2 unsigned, early exit and full-length equal.
    launch(1, 8'hA5, 8'h95, 1'b0, GT, 2);
    wait_done(1);
    launch(1, 8'h3C, 8'h3C, 1'b0, EQ, 4);
    // Start pulse with different operands while busy must be ignored.
    a_v[1]     = 8'h00;
    b_v[1]     = 8'hFF;
    sm_v[1]    = 1'b1;
    start_v[1] = 1'b1;
    @(negedge clock);
    start_v[1] = 1'b0;
    wait_done(1);

    // 8/2 signed vs unsigned ordering.
    launch(1, 8'hFE, 8'h01, 1'b1, LT, 1);
    wait_done(1);
    launch(1, 8'hFE, 8'h01, 1'b0, GT, 1);
    wait_done(1);

    // 8/8 single-digit compare.
    launch(2, 8'h80, 8'h7F, 1'b1, LT, 1);
    wait_done(2);
    launch(2, 8'h80, 8'h7F, 1'b0, GT, 1);
    wait_done(2);
    @(negedge clock);

    // Reset two cycles into a 4-digit compare aborts it.
    launch(0, 8'h0E, 8'h0F, 1'b0, LT, 4);
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("busy_before_abort", int'(busy_v[0]), 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_done", int'(done_v[0]), 0);
    chk("abort_flags", int'({gt_v[0], lt_v[0], eq_v[0]}), 0);
    chk("abort_cnt", int'(dcnt_v[0]), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      chk("no_done_after_abort", int'(done_v[0]), 0);
    end

    // Normal compare after the abort.
    launch(0, 8'h0A, 8'h09, 1'b0, GT, 3);
    wait_done(0);

    repeat (5) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
